// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer_if
//  Description : Sample, coefficient and result signals for fir_mac_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_mac_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  flush;
    logic                  coef_wr_en;
    logic [ADDR_WIDTH-1:0] coef_wr_addr;
    logic [COEF_WIDTH-1:0] coef_wr_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  busy;

    modport master (
        output in_valid, in_data, flush, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, flush, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Time-multiplexed FIR, one shared signed MAC stepped over all taps.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fir_mac_sequencer_if.slave sif
);
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_k = ADDR_WIDTH'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic signed [DATA_WIDTH-1:0]  r_hist [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  r_coef [NUM_TAPS];
    logic        [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic        [ADDR_WIDTH-1:0]  r_base;
    logic        [ADDR_WIDTH-1:0]  r_k;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic        [ACC_WIDTH-1:0]   r_out_data;

    logic                          w_in_ready;
    logic                          w_out_valid;
    logic                          w_busy;
    logic                          w_accept;
    logic        [ADDR_WIDTH-1:0]  w_idx;
    logic signed [PROD_WIDTH-1:0]  w_prod;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;

    // Newest sample sits at base; older taps walk backwards around the ring.
    assign w_idx      = r_base - r_k;
    assign w_prod     = r_hist[w_idx] * r_coef[r_k];
    assign w_acc_next = r_acc + ACC_WIDTH'(w_prod);
    assign w_accept   = w_in_ready & sif.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                // flush wins over a simultaneous sample, so the sample is refused
                w_in_ready = ~rst & ~sif.flush;
                if (w_in_ready && sif.in_valid) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (r_k == c_last_k) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (sif.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_hist[i] <= '0;
                r_coef[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_base     <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sif.coef_wr_en) begin
                        r_coef[sif.coef_wr_addr] <= sif.coef_wr_data;
                    end
                    if (sif.flush) begin
                        for (int i = 0; i < NUM_TAPS; i++) begin
                            r_hist[i] <= '0;
                        end
                        r_wr_ptr <= '0;
                    end else if (w_accept) begin
                        r_hist[r_wr_ptr] <= sif.in_data;
                        r_acc            <= '0;
                        r_k              <= '0;
                        r_base           <= r_wr_ptr;
                        r_wr_ptr         <= r_wr_ptr + 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    if (r_k == c_last_k) begin
                        r_out_data <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sif.in_ready  = w_in_ready;
    assign sif.out_valid = w_out_valid;
    assign sif.out_data  = r_out_data;
    assign sif.busy      = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sequencer
//  Description : Directed, table-driven self-checking bench for fir_mac_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mac_sequencer;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 8;
    localparam int AW = 40;
    localparam int KW = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fir_mac_sequencer_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(AW), .ADDR_WIDTH(KW)) bus ();

    fir_mac_sequencer #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .ACC_WIDTH(AW), .ADDR_WIDTH(KW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus.slave)
    );

    typedef struct {
        logic signed [DW-1:0] x;
        logic        [AW-1:0] y;
    } vec_t;

    vec_t tbl [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [KW-1:0] a, input logic signed [CW-1:0] d);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = a;
        bus.coef_wr_data = d;
        step();
        bus.coef_wr_en   = 1'b0;
    endtask

    task automatic accept(input logic signed [DW-1:0] x);
        int t = 0;
        while (!bus.in_ready && t < 20) begin
            step();
            t++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output logic [AW-1:0] y, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        y = bus.out_data;
    endtask

    task automatic run_table(input string tag);
        logic [AW-1:0] y;
        int            lat;
        for (int i = 0; i < 9; i++) begin
            accept(tbl[i].x);
            wait_valid(y, lat);
            chk($sformatf("%s_y%0d", tag, i), 64'(y), 64'(tbl[i].y));
            if (i == 0) chk({tag, "_latency"}, 64'(lat), 64'd8);
            step();
            chk($sformatf("%s_ready_after%0d", tag, i), 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [AW-1:0] y;
        logic [AW-1:0] held;
        int            lat;
        logic          seen;

        n_cmp = 0;
        n_err = 0;
        tbl[0] = '{16'sd1, 40'd1};
        tbl[1] = '{16'sd0, 40'd2};
        tbl[2] = '{16'sd0, 40'd3};
        tbl[3] = '{16'sd0, 40'd4};
        tbl[4] = '{16'sd0, 40'd5};
        tbl[5] = '{16'sd0, 40'd6};
        tbl[6] = '{16'sd0, 40'd7};
        tbl[7] = '{16'sd0, 40'd8};
        tbl[8] = '{16'sd0, 40'd0};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.flush = 1'b0;
        bus.coef_wr_en = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Impulse response with c[k] = k+1
        for (int k = 0; k < NT; k++) write_coef(KW'(k), CW'(k + 1));
        run_table("impulse");

        // Signed arithmetic
        for (int k = 1; k < NT; k++) write_coef(KW'(k), '0);
        write_coef(3'd0, -16'sd3);
        accept(-16'sd4);
        wait_valid(y, lat);
        chk("signed_neg_neg", 64'(y), 64'd12);
        step();
        write_coef(3'd0, -16'sd32768);
        accept(16'sd32767);
        wait_valid(y, lat);
        chk("signed_extreme", 64'(y), 64'h00FF_C000_8000);
        step();

        // Backpressure: c[0] = -32768, sample 2 -> -65536
        bus.out_ready = 1'b0;
        accept(16'sd2);
        wait_valid(held, lat);
        chk("bp_value", 64'(held), 64'h00FF_FFFF_0000);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_data%0d", c), 64'(bus.out_data), 64'h00FF_FFFF_0000);
            chk($sformatf("bp_in_ready%0d", c), 64'(bus.in_ready), 64'd0);
            chk($sformatf("bp_busy%0d", c), 64'(bus.busy), 64'd1);
            chk($sformatf("bp_valid%0d", c), 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_busy", 64'(bus.busy), 64'd0);
        chk("bp_release_data", 64'(bus.out_data), 64'h00FF_FFFF_0000);

        // Coefficient write on the acceptance edge is used by that computation
        bus.coef_wr_en = 1'b1;
        bus.coef_wr_addr = 3'd0;
        bus.coef_wr_data = 16'sd2;
        accept(16'sd5);
        bus.coef_wr_en = 1'b0;
        wait_valid(y, lat);
        chk("same_edge_write", 64'(y), 64'd10);
        step();

        // Writes during MAC/OUT are ignored
        write_coef(3'd0, 16'sd7);
        accept(16'sd3);
        bus.coef_wr_en = 1'b1;
        bus.coef_wr_addr = 3'd0;
        bus.coef_wr_data = 16'sd100;
        wait_valid(y, lat);
        bus.coef_wr_en = 1'b0;
        chk("ignored_write_result", 64'(y), 64'd21);
        step();
        accept(16'sd1);
        wait_valid(y, lat);
        chk("ignored_write_kept", 64'(y), 64'd7);
        step();

        // flush beats in_valid, then impulse from cleared history
        for (int k = 0; k < NT; k++) write_coef(KW'(k), CW'(k + 1));
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'sd9;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_not_accepted", 64'(bus.busy), 64'd0);
        run_table("flushed");

        // Reset during MAC
        accept(16'sd9);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midmac_in_ready_rst", 64'(bus.in_ready), 64'd0);
        step();
        rst = 1'b0;
        chk("midmac_busy", 64'(bus.busy), 64'd0);
        chk("midmac_out_data", 64'(bus.out_data), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        chk("midmac_no_output", 64'(seen), 64'd0);
        write_coef(3'd0, 16'sd1);
        write_coef(3'd1, 16'sd1);
        accept(16'sd5);
        wait_valid(y, lat);
        chk("midmac_cleared_hist", 64'(y), 64'd5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
